mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the 16-bit pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes that register's held outputs (control word, ALU result, store data, PC+2). It sequences loads and stores against a variable-latency data memory using a request/done handshake. It stalls the upstream pipeline while an access is outstanding, then registers the retired instruction into the MEM/WB boundary outputs.

## Interface
Parameters:
- TIMEOUT, 255: maximum WAIT cycles before an access is abandoned. Counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-low
- ctrl  in  16  EX/MEM control word. Bit 0 MemRead, bit 1 MemWrite, bit 2 RegWrite, bit 3 MemToReg, bit 4 Halt; other bits pass through untouched.
- aluRslt  in  16  effective address / ALU result
- readD2  in  16  store data
- PC2  in  16  PC+2 of the instruction
- mem_rdata  in  16  read data; valid when mem_done=1
- mem_done  in  1  memory completion; sampled only in WAIT
- mem_req  out  1  access request, held high until completion
- mem_wr  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  16  equals aluRslt while mem_req=1
- mem_wdata  out  16  equals readD2 while mem_req=1
- Stall  out  1  holds EX/MEM and earlier stages (combinational)
- wb_ctrl, wb_aluRslt, wb_memData, wb_PC2  out  16 each  MEM/WB registered outputs
- mem_err  out  1  sticky timeout flag

## Operation
- Memory op = ctrl[0] | ctrl[1]. If both bits are set, the op is a write (write priority).
- FSM states: IDLE, WAIT.
- IDLE, non-memory op:
  - No request and Stall=0.
  - At the edge: wb_ctrl<=ctrl, wb_aluRslt<=aluRslt, wb_PC2<=PC2, wb_memData<=0.
- IDLE, memory op:
  - mem_req=1 and Stall=1. mem_wr, mem_addr and mem_wdata are driven from the inputs.
  - Next state WAIT; counter<=0.
  - MEM/WB loads a bubble: all wb_* <= 0.
- WAIT:
  - mem_req=1; the inputs are stable because EX/MEM is stalled.
  - Stall = ~mem_done & ~timeout_hit, where timeout_hit = (counter == TIMEOUT-1).
- WAIT with mem_done=1:
  - Retire the instruction: wb_ctrl<=ctrl, wb_aluRslt<=aluRslt, wb_PC2<=PC2.
  - wb_memData<=mem_rdata for a read, 0 for a write.
  - Next state IDLE.
- WAIT with mem_done=0:
  - If timeout_hit: retire with wb_ctrl<=ctrl with bit 2 cleared and wb_memData<=0; mem_err<=1; go to IDLE.
  - Otherwise counter increments and MEM/WB loads a bubble.
- mem_done and timeout_hit in the same cycle: done wins and mem_err is unchanged.
- mem_done in IDLE is ignored.
- mem_err clears only on reset.

## Timing
- Reset (rst=0 at an edge): state IDLE, counter 0, all wb_* = 0, mem_err 0.
  - mem_req, mem_wr, Stall follow the IDLE rules (0 when ctrl is not a memory op).
  - An access in flight is abandoned without completion.
- Non-memory instruction: 1 cycle in stage, zero stall.
- Memory instruction with done on the k-th WAIT cycle (k≥1):
  - Stall is high for k cycles (the IDLE issue cycle plus k-1 WAIT cycles).
  - The instruction occupies the stage k+1 cycles.
  - wb_* are valid the cycle after done.
- The Stall falling edge coincides with the retire edge. EX/MEM advances on that same edge, so the next instruction is evaluated in IDLE the following cycle. Back-to-back memory ops therefore never share a request.
- Timeout: with no done, the stage retires on WAIT cycle TIMEOUT. Stall is high for TIMEOUT cycles in total.
- mem_req is never high for two different instructions without an intervening IDLE cycle.

## Test plan
- Reset: drive rst=0 with ctrl=16'h0001 held for 2 cycles → after the edge, wb_*=0 and mem_err=0. Release rst → mem_req=1 in IDLE.
- ALU pass-through: ctrl=16'h0004, aluRslt=16'h1234, PC2=16'h0010 → Stall=0 throughout; next cycle wb_ctrl=16'h0004, wb_aluRslt=16'h1234, wb_memData=0.
- Load, 3-cycle memory: ctrl=16'h000D, aluRslt=16'h0040; done with rdata=16'hBEEF on the 3rd WAIT cycle → Stall high 3 cycles, mem_addr=16'h0040, mem_wr=0; next cycle wb_memData=16'hBEEF, wb_ctrl=16'h000D.
- Store, done on 1st WAIT cycle: ctrl=16'h0002, readD2=16'hA5A5 → mem_wr=1, mem_wdata=16'hA5A5, Stall high exactly 1 cycle; wb_memData=0.
- Timeout with TIMEOUT=4: load with mem_done never asserted → Stall high 4 cycles; wb_ctrl has bit 2 cleared; mem_err=1 and it stays 1 through a following ALU op.
- Reset mid-WAIT: rst=0 during the 2nd WAIT cycle → next cycle state IDLE, counter 0, wb_*=0, and no retire of the abandoned load.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: sequences loads/stores against a variable-latency data
// memory, stalls upstream while an access is outstanding, and registers MEM/WB.
module mem_access_stage #(
  parameter int TIMEOUT = 255,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ctrl,
  input  logic [DATA_W-1:0] aluRslt,
  input  logic [DATA_W-1:0] readD2,
  input  logic [DATA_W-1:0] PC2,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              Stall,
  output logic [DATA_W-1:0] wb_ctrl,
  output logic [DATA_W-1:0] wb_aluRslt,
  output logic [DATA_W-1:0] wb_memData,
  output logic [DATA_W-1:0] wb_PC2,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_mem;
  logic               timeout_hit;
  logic               retire;
  logic               err_set;
  logic [DATA_W-1:0]  wb_ctrl_nxt;
  logic [DATA_W-1:0]  wb_mem_data_nxt;

  assign is_mem    = ctrl[0] | ctrl[1];
  // Write has priority when both MemRead and MemWrite are set.
  assign mem_wr    = mem_req & ctrl[1];
  assign mem_addr  = aluRslt;
  assign mem_wdata = readD2;

  always_comb begin
    state_nxt       = state;
    mem_req         = 1'b0;
    Stall           = 1'b0;
    retire          = 1'b0;
    err_set         = 1'b0;
    timeout_hit     = 1'b0;
    wb_ctrl_nxt     = ctrl;
    wb_mem_data_nxt = '0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          mem_req   = 1'b1;
          Stall     = 1'b1;
          state_nxt = WAIT;
        end else begin
          retire = 1'b1;
        end
      end
      WAIT: begin
        mem_req     = 1'b1;
        timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
        Stall       = ~mem_done & ~timeout_hit;
        // Completion beats timeout when both land in the same cycle.
        if (mem_done) begin
          retire          = 1'b1;
          wb_mem_data_nxt = ctrl[1] ? '0 : mem_rdata;
          state_nxt       = IDLE;
        end else if (timeout_hit) begin
          retire         = 1'b1;
          err_set        = 1'b1;
          wb_ctrl_nxt[2] = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE || retire) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
      if (err_set) mem_err <= 1'b1;
    end
  end

  // MEM/WB boundary: a bubble is loaded on every edge that does not retire.
  always_ff @(posedge clk) begin
    if (!rst || !retire) begin
      wb_ctrl    <= '0;
      wb_aluRslt <= '0;
      wb_memData <= '0;
      wb_PC2     <= '0;
    end else begin
      wb_ctrl    <= wb_ctrl_nxt;
      wb_aluRslt <= aluRslt;
      wb_memData <= wb_mem_data_nxt;
      wb_PC2     <= PC2;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random instruction stream
// checked against a transaction-level model of the stage.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ctrl, aluRslt, readD2, PC2, mem_rdata;
  logic        mem_done;
  logic        mem_req, mem_wr, Stall, mem_err;
  logic [15:0] mem_addr, mem_wdata, wb_ctrl, wb_aluRslt, wb_memData, wb_PC2;

  int errors = 0;
  int checks = 0;
  bit err_model = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TO), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .aluRslt(aluRslt), .readD2(readD2),
    .PC2(PC2), .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .Stall(Stall),
    .wb_ctrl(wb_ctrl), .wb_aluRslt(wb_aluRslt), .wb_memData(wb_memData),
    .wb_PC2(wb_PC2), .mem_err(mem_err)
  );

  // Runs one instruction through the stage. Called and returns at a negedge.
  // k = WAIT cycle on which mem_done is given (0 = never).
  task automatic run_op(input logic [15:0] c, input logic [15:0] a,
                        input logic [15:0] d2, input logic [15:0] pc,
                        input int k, input logic [15:0] rd, input string nm);
    bit          is_mem, is_wr, timed_out, retired;
    int          exp_stall, stalls;
    logic [15:0] e_ctrl, e_mem;
    is_mem    = c[0] | c[1];
    is_wr     = c[1];
    timed_out = is_mem && (k == 0 || k > TO);
    exp_stall = !is_mem ? 0 : (timed_out ? TO : k);
    e_ctrl    = timed_out ? (c & ~16'h0004) : c;
    e_mem     = (!is_mem || is_wr || timed_out) ? 16'h0 : rd;
    ctrl = c; aluRslt = a; readD2 = d2; PC2 = pc; mem_rdata = rd;
    mem_done = 1'($urandom_range(0, 1));
    stalls = 0; retired = 1'b0;
    for (int cyc = 0; cyc < TO + 3; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        mem_done  = (cyc == k);
        mem_rdata = rd;
      end
      #1;
      checks++;
      if (mem_req !== is_mem) begin
        errors++;
        $display("FAIL %s mem_req cyc%0d: got %b want %b", nm, cyc, mem_req, is_mem);
      end
      if (cyc == 0 && is_mem) begin
        checks++;
        if (mem_wr !== is_wr || mem_addr !== a || mem_wdata !== d2) begin
          errors++;
          $display("FAIL %s req_fields: got wr=%b addr=%h wd=%h want wr=%b addr=%h wd=%h",
                   nm, mem_wr, mem_addr, mem_wdata, is_wr, a, d2);
        end
      end
      if (cyc > 0) begin
        checks++;
        if (wb_ctrl !== 16'h0 || wb_memData !== 16'h0) begin
          errors++;
          $display("FAIL %s bubble cyc%0d: got wb_ctrl=%h wb_memData=%h want 0", nm, cyc, wb_ctrl, wb_memData);
        end
      end
      if (Stall === 1'b1) stalls++;
      else retired = 1'b1;
      @(posedge clk);
      if (retired) break;
    end
    if (!retired) begin
      errors++;
      $display("FAIL %s no_retire: got stall>%0d cycles want %0d", nm, TO + 2, exp_stall);
    end
    @(negedge clk);
    mem_done = 1'b0;
    if (timed_out) err_model = 1'b1;
    #1;
    checks++;
    if (stalls !== exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, stalls, exp_stall);
    end
    checks++;
    if (wb_ctrl !== e_ctrl || wb_aluRslt !== a || wb_memData !== e_mem || wb_PC2 !== pc) begin
      errors++;
      $display("FAIL %s wb: got %h/%h/%h/%h want %h/%h/%h/%h", nm,
               wb_ctrl, wb_aluRslt, wb_memData, wb_PC2, e_ctrl, a, e_mem, pc);
    end
    checks++;
    if (mem_err !== err_model) begin
      errors++;
      $display("FAIL %s mem_err: got %b want %b", nm, mem_err, err_model);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ctrl = 16'h0001; aluRslt = 16'h1111; readD2 = 16'h2222;
    PC2 = 16'h3333; mem_rdata = 16'h0; mem_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    err_model = 1'b0;
    checks++;
    if (wb_ctrl !== 0 || wb_aluRslt !== 0 || wb_memData !== 0 || wb_PC2 !== 0 || mem_err !== 0) begin
      errors++;
      $display("FAIL reset_state: got %h/%h/%h/%h err=%b want all 0", wb_ctrl, wb_aluRslt, wb_memData, wb_PC2, mem_err);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || Stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_req: got req=%b stall=%b want 1/1", mem_req, Stall);
    end
    ctrl = 16'h0000;
    #1;
    checks++;
    if (mem_req !== 1'b0 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_nonmem: got req=%b stall=%b want 0/0", mem_req, Stall);
    end
  endtask

  task automatic test_alu();
    run_op(16'h0004, 16'h1234, 16'h5555, 16'h0010, 0, 16'h9999, "alu");
  endtask

  task automatic test_load();
    run_op(16'h000D, 16'h0040, 16'h0000, 16'h0020, 3, 16'hBEEF, "load3");
  endtask

  task automatic test_store();
    run_op(16'h0002, 16'h0080, 16'hA5A5, 16'h0030, 1, 16'h7777, "store1");
    run_op(16'h0003, 16'h0082, 16'h5A5A, 16'h0032, 2, 16'h7777, "rw_is_write");
  endtask

  task automatic test_timeout();
    run_op(16'h000D, 16'h0100, 16'h0000, 16'h0040, 0, 16'h1234, "timeout");
    run_op(16'h0004, 16'h0101, 16'h0000, 16'h0042, 0, 16'h0000, "alu_after_to");
    run_op(16'h0005, 16'h0102, 16'h0000, 16'h0044, TO, 16'hC0DE, "done_at_to");
  endtask

  task automatic test_reset_mid_wait();
    ctrl = 16'h000D; aluRslt = 16'h0200; PC2 = 16'h0050; mem_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_done = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; mem_done = 1'b0; err_model = 1'b0;
    ctrl = 16'h0000;
    #1;
    checks++;
    if (wb_ctrl !== 0 || wb_aluRslt !== 0 || wb_memData !== 0 || wb_PC2 !== 0 || mem_err !== 0) begin
      errors++;
      $display("FAIL midwait_reset_wb: got %h/%h/%h/%h err=%b want all 0", wb_ctrl, wb_aluRslt, wb_memData, wb_PC2, mem_err);
    end
    checks++;
    if (mem_req !== 1'b0 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL midwait_reset_idle: got req=%b stall=%b want 0/0", mem_req, Stall);
    end
    run_op(16'h0001, 16'h0204, 16'h0000, 16'h0052, 0, 16'h0000, "to_after_rst");
  endtask

  task automatic test_back_to_back();
    run_op(16'h0009, 16'h0300, 16'h0000, 16'h0060, 1, 16'h1357, "b2b_a");
    run_op(16'h0002, 16'h0302, 16'hFACE, 16'h0062, 1, 16'h2468, "b2b_b");
    run_op(16'h000D, 16'h0304, 16'h0000, 16'h0064, 2, 16'h3579, "b2b_c");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [15:0] c;
      c = 16'($urandom);
      if ($urandom_range(0, 2) == 0) c[1:0] = 2'b00;
      run_op(c, 16'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, TO + 1)), 16'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
